// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding initiator for the data-memory port.
// Supports byte/half/word accesses with sign/zero-extended loads and
// read-modify-write sub-word stores, plus alignment and range checking.
//
// Handshake: a request transfers on a posedge where req_valid && req_ready.
// req_ready is high only in IDLE. Request fields are captured on that edge
// and need not be held afterwards. resp_valid is a one-cycle pulse with no
// back-pressure; resp_rdata/resp_misaligned/resp_oob are valid with it.
module load_store_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_oob,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [15:0] wdata_q;

  logic        misaligned;
  logic        oob;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Memory strobes and handshake outputs are pure decodes of the state register.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_read   = (state == LOAD) || (state == RMW_READ);
  assign mem_write  = (state == WRITE);
  assign dbg_state  = state;

  // Classify the incoming request: alignment and address-range errors.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    oob = (req_addr >= ADDR_LIMIT);
  end

  // Lane extraction for loads and lane merge for sub-word stores (little-endian).
  always_comb begin
    byte_sel = 8'h00;
    case (lane_q)
      2'd0:    byte_sel = mem_read_data[7:0];
      2'd1:    byte_sel = mem_read_data[15:8];
      2'd2:    byte_sel = mem_read_data[23:16];
      default: byte_sel = mem_read_data[31:24];
    endcase
    half_sel = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    load_val = mem_read_data;
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_val = uns_q ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = mem_read_data;
    endcase

    merged = mem_read_data;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Control FSM and all registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      lane_q          <= 2'd0;
      size_q          <= 2'd0;
      uns_q           <= 1'b0;
      wdata_q         <= 16'h0000;
      mem_address     <= 32'h0;
      mem_write_data  <= 32'h0;
      resp_rdata      <= 32'h0;
      resp_misaligned <= 1'b0;
      resp_oob        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lane_q          <= req_addr[1:0];
            size_q          <= req_size;
            uns_q           <= req_unsigned;
            wdata_q         <= req_wdata[15:0];
            mem_address     <= {req_addr[31:2], 2'b00};
            resp_misaligned <= misaligned;
            resp_oob        <= oob;
            if (misaligned || oob) begin
              resp_rdata <= 32'h0;
              state      <= RESP;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (req_size == 2'b10) begin
              mem_write_data <= req_wdata;
              state          <= WRITE;
            end else begin
              state <= RMW_READ;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_val;
          state      <= RESP;
        end
        RMW_READ: begin
          mem_write_data <= merged;
          state          <= WRITE;
        end
        WRITE: begin
          resp_rdata <= 32'h0;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: behavioural word memory as the data_memory,
// a byte-array reference model, and directed plus randomized scenarios.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_oob;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;
  logic [2:0]  dbg_state;

  int n_pass;
  int n_total;

  // Bench-side memory and reference byte model
  logic [31:0] mem [0:255];
  logic [7:0]  ref_mem [0:1023];

  // Monitor counters (sampled on negedge)
  int rd_cnt;
  int wr_cnt;
  int both_cnt;

  // Observed results of the last transaction
  int          lat;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_mis;
  logic        r_oob;
  logic        r_after;
  // Bench-computed expectations for the last transaction
  int          e_lat;
  logic [31:0] e_rdata;
  logic        e_mis;
  logic        e_oob;

  logic [31:0] exp_q[$];

  load_store_unit #(.ADDR_LIMIT(32'd1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_oob(resp_oob),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- data memory ----------------
  assign mem_read_data = mem[mem_address[9:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
  end

  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read && mem_write) both_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [9:0]  i;
    logic [7:0]  b;
    logic [15:0] h;
    i = a[9:0];
    if (sz == 2'b00) begin
      b = ref_mem[i];
      return uns ? {24'h0, b} : {{24{b[7]}}, b};
    end else if (sz == 2'b01) begin
      h = {ref_mem[i + 10'd1], ref_mem[i]};
      return uns ? {16'h0, h} : {{16{h[15]}}, h};
    end
    return {ref_mem[i + 10'd3], ref_mem[i + 10'd2], ref_mem[i + 10'd1], ref_mem[i]};
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [9:0] i;
    i = a[9:0];
    ref_mem[i] = wd[7:0];
    if (sz != 2'b00) ref_mem[i + 10'd1] = wd[15:8];
    if (sz == 2'b10) begin
      ref_mem[i + 10'd2] = wd[23:16];
      ref_mem[i + 10'd3] = wd[31:24];
    end
  endtask

  // ---------------- driver ----------------
  // Call with the unit idle, away from a posedge. Computes expectations from the
  // reference model, runs one request and records what the DUT showed.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    e_mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    e_oob = (a >= 32'd1024);
    if (e_mis || e_oob) begin
      e_lat = 1; e_rdata = 32'h0;
    end else if (!we) begin
      e_lat = 2; e_rdata = ref_load(sz, uns, a);
    end else begin
      e_lat = (sz == 2'b10) ? 2 : 3; e_rdata = 32'h0;
      ref_store(sz, a, wd);
    end
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    r_valid = resp_valid; r_rdata = resp_rdata; r_mis = resp_misaligned; r_oob = resp_oob;
    @(posedge clk); #1;
    r_after = resp_valid;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else n_pass++;
    n_total++; if (resp_valid !== 1'b0 || resp_misaligned !== 1'b0 || resp_oob !== 1'b0)
      $display("FAIL reset_resp_flags got %b%b%b exp 000", resp_valid, resp_misaligned, resp_oob); else n_pass++;
    n_total++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", resp_rdata); else n_pass++;
    n_total++; if (mem_read !== 1'b0 || mem_write !== 1'b0)
      $display("FAIL reset_mem_strobes got %b%b exp 00", mem_read, mem_write); else n_pass++;
    n_total++; if (mem_address !== 32'h0 || mem_write_data !== 32'h0)
      $display("FAIL reset_mem_bus got %h/%h exp 0/0", mem_address, mem_write_data); else n_pass++;
  endtask

  task automatic test_loads;
    do_req(1'b0, 2'b00, 1'b0, 32'h1, 32'h0);
    n_total++; if (r_rdata !== 32'hFFFFFFCC) $display("FAIL lb_0x1 got %h exp FFFFFFCC", r_rdata); else n_pass++;
    n_total++; if (lat !== 2) $display("FAIL lb_latency got %0d exp 2", lat); else n_pass++;
    n_total++; if (r_after !== 1'b0) $display("FAIL resp_pulse_width got %b exp 0", r_after); else n_pass++;
    do_req(1'b0, 2'b00, 1'b1, 32'h3, 32'h0);
    n_total++; if (r_rdata !== 32'h000000AA) $display("FAIL lbu_0x3 got %h exp 000000AA", r_rdata); else n_pass++;
    do_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    n_total++; if (r_rdata !== 32'hFFFFAABB) $display("FAIL lh_0x2 got %h exp FFFFAABB", r_rdata); else n_pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    n_total++; if (r_rdata !== 32'hAABBCCDD || r_mis !== 1'b0 || r_oob !== 1'b0)
      $display("FAIL lw_0x0 got %h/%b/%b exp AABBCCDD/0/0", r_rdata, r_mis, r_oob); else n_pass++;
  endtask

  task automatic test_stores;
    int w0;
    w0 = wr_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h2, 32'h12345611);
    n_total++; if (lat !== 3) $display("FAIL sb_latency got %0d exp 3", lat); else n_pass++;
    n_total++; if (wr_cnt - w0 !== 1) $display("FAIL sb_write_pulses got %0d exp 1", wr_cnt - w0); else n_pass++;
    n_total++; if (r_rdata !== 32'h0) $display("FAIL sb_rdata_cleared got %h exp 0", r_rdata); else n_pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    n_total++; if (r_rdata !== 32'hAA11CCDD) $display("FAIL lw_after_sb got %h exp AA11CCDD", r_rdata); else n_pass++;
    do_req(1'b1, 2'b01, 1'b0, 32'h0, 32'h0000BEEF);
    n_total++; if (lat !== 3) $display("FAIL sh_latency got %0d exp 3", lat); else n_pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    n_total++; if (r_rdata !== 32'hAA11BEEF) $display("FAIL lw_after_sh got %h exp AA11BEEF", r_rdata); else n_pass++;
    w0 = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEF00D);
    n_total++; if (lat !== 2 || wr_cnt - w0 !== 1)
      $display("FAIL sw_latency_pulses got %0d/%0d exp 2/1", lat, wr_cnt - w0); else n_pass++;
    do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
    n_total++; if (r_rdata !== 32'h0000CAFE) $display("FAIL lhu_after_sw got %h exp 0000CAFE", r_rdata); else n_pass++;
  endtask

  task automatic test_errors;
    int r0;
    int w0;
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h6, 32'h11111111);
    n_total++; if (r_mis !== 1'b1 || r_oob !== 1'b0 || lat !== 1)
      $display("FAIL sw_0x6_misaligned got %b/%b lat %0d exp 1/0 lat 1", r_mis, r_oob, lat); else n_pass++;
    n_total++; if (rd_cnt != r0 || wr_cnt != w0)
      $display("FAIL err_no_mem_cycle got rd %0d wr %0d exp 0 0", rd_cnt - r0, wr_cnt - w0); else n_pass++;
    n_total++; if (r_rdata !== 32'h0) $display("FAIL err_rdata_cleared got %h exp 0", r_rdata); else n_pass++;
    do_req(1'b0, 2'b11, 1'b0, 32'h8, 32'h0);
    n_total++; if (r_mis !== 1'b1) $display("FAIL size11_misaligned got %b exp 1", r_mis); else n_pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    n_total++; if (r_oob !== 1'b1 || r_mis !== 1'b0)
      $display("FAIL lw_0x400_oob got %b/%b exp oob 1 mis 0", r_oob, r_mis); else n_pass++;
    do_req(1'b0, 2'b01, 1'b0, 32'h401, 32'h0);
    n_total++; if (r_oob !== 1'b1 || r_mis !== 1'b1)
      $display("FAIL lh_0x401_both got %b/%b exp 1/1", r_oob, r_mis); else n_pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
    n_total++; if (r_oob !== 1'b0 || r_mis !== 1'b0 || r_rdata !== e_rdata)
      $display("FAIL lw_0x3fc_last got %h/%b/%b exp %h/0/0", r_rdata, r_oob, r_mis, e_rdata); else n_pass++;
    do_req(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
    n_total++; if (r_mis !== 1'b1) $display("FAIL lh_odd_misaligned got %b exp 1", r_mis); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic        b_we [3];
    logic [1:0]  b_sz [3];
    logic        b_un [3];
    logic [31:0] b_ad [3];
    logic [31:0] b_wd [3];
    int          n_resp;
    logic        timed_out;
    b_we[0] = 1'b0; b_sz[0] = 2'b10; b_un[0] = 1'b0; b_ad[0] = 32'h0; b_wd[0] = 32'h0;
    b_we[1] = 1'b1; b_sz[1] = 2'b00; b_un[1] = 1'b0; b_ad[1] = 32'h9; b_wd[1] = 32'hFFFFFF5A;
    b_we[2] = 1'b0; b_sz[2] = 2'b00; b_un[2] = 1'b1; b_ad[2] = 32'h9; b_wd[2] = 32'h0;
    n_resp = 0;
    timed_out = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int cyc;
          req_we = b_we[i]; req_size = b_sz[i]; req_unsigned = b_un[i];
          req_addr = b_ad[i]; req_wdata = b_wd[i]; req_valid = 1'b1;
          cyc = 0;
          while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
          end
          if (!req_ready) timed_out = 1'b1;
          if (b_we[i]) begin
            ref_store(b_sz[i], b_ad[i], b_wd[i]);
            exp_q.push_back(32'h0);
          end else begin
            exp_q.push_back(ref_load(b_sz[i], b_un[i], b_ad[i]));
          end
          @(posedge clk);
          @(negedge clk);
        end
        req_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if (resp_valid) begin
            logic [31:0] exp_v;
            n_resp++;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADDEAD;
            n_total++;
            if (resp_rdata !== exp_v) $display("FAIL b2b_resp%0d got %h exp %h", n_resp, resp_rdata, exp_v);
            else n_pass++;
          end
        end
      end
    join
    n_total++; if (timed_out) $display("FAIL b2b_accept_timeout got timeout exp accept"); else n_pass++;
    n_total++; if (n_resp !== 3 || exp_q.size() !== 0)
      $display("FAIL b2b_resp_count got %0d left %0d exp 3 left 0", n_resp, exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] old_w;
    int          w0;
    old_w = mem[0];
    w0 = wr_cnt;
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h00000077;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_total++; if (mem_read !== 1'b1) $display("FAIL rmw_read_active got %b exp 1", mem_read); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_total++; if (req_ready !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL midop_reset_ctrl got rdy %b rd %b wr %b rv %b exp 1 0 0 0",
               req_ready, mem_read, mem_write, resp_valid); else n_pass++;
    n_total++; if (mem_address !== 32'h0 || mem_write_data !== 32'h0 || resp_rdata !== 32'h0)
      $display("FAIL midop_reset_regs got %h/%h/%h exp 0/0/0", mem_address, mem_write_data, resp_rdata); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (wr_cnt != w0 || mem[0] !== old_w)
      $display("FAIL midop_no_write got wr %0d mem0 %h exp 0 %h", wr_cnt - w0, mem[0], old_w); else n_pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    n_total++; if (r_rdata !== old_w) $display("FAIL lw_after_abort got %h exp %h", r_rdata, old_w); else n_pass++;
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          s;
      s  = $urandom_range(0, 9);
      sz = (s < 3) ? 2'b00 : (s < 6) ? 2'b01 : (s < 9) ? 2'b10 : 2'b11;
      a  = ($urandom_range(0, 9) == 0) ? 32'h400 + $urandom_range(0, 15) : $urandom_range(0, 63);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      n_total++;
      if (r_valid !== 1'b1 || lat !== e_lat || r_rdata !== e_rdata || r_mis !== e_mis || r_oob !== e_oob)
        $display("FAIL rand%0d got lat %0d rd %h mis %b oob %b exp lat %0d rd %h mis %b oob %b",
                 n, lat, r_rdata, r_mis, r_oob, e_lat, e_rdata, e_mis, e_oob);
      else n_pass++;
    end
    n_total++; if (both_cnt !== 0) $display("FAIL read_write_overlap got %0d exp 0", both_cnt); else n_pass++;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    n_pass = 0; n_total = 0;
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    mem[0] = 32'hAABBCCDD;
    for (int i = 1; i < 256; i++) mem[i] = i * 32'h9E3779B1;
    for (int i = 0; i < 256; i++) begin
      for (int b = 0; b < 4; b++) ref_mem[i * 4 + b] = mem[i][b * 8 +: 8];
    end
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_loads;
    test_stores;
    test_errors;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
